// File: rtl/rsfq_pulse_tx.sv
// Toggle-encoded stimulus transmitter for clocked two-input RSFQ cells.
// Spaces a/b/clk edges to honour a-to-b separation, setup and hold, and tracks expected q.
module rsfq_pulse_tx #(
  parameter int AB_GAP = 8,
  parameter int SETUP  = 5,
  parameter int HOLD   = 5,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_a,
  input  logic             in_b,
  output logic             a_t,
  output logic             b_t,
  output logic             clk_t,
  output logic             exp_q,
  output logic [CNT_W-1:0] clk_count
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND_A   = 3'd1,
    GAP      = 3'd2,
    SEND_B   = 3'd3,
    SETUP_W  = 3'd4,
    SEND_CLK = 3'd5,
    HOLD_W   = 3'd6
  } state_t;

  // Wait-state lengths exclude the SEND_x cycle that precedes the next edge.
  localparam logic [7:0] GAP_LEN   = 8'(AB_GAP - 1);
  localparam logic [7:0] SETUP_LEN = 8'(SETUP - 1);
  localparam logic [7:0] HOLD_LEN  = 8'(HOLD - 1);

  state_t           state_r, state_s;
  logic [7:0]       cnt_r, cnt_s;
  logic             word_a_r, word_a_s;
  logic             word_b_r, word_b_s;
  logic             in_ready_r, in_ready_s;
  logic             a_t_r, a_t_s;
  logic             b_t_r, b_t_s;
  logic             clk_t_r, clk_t_s;
  logic             exp_q_r, exp_q_s;
  logic [CNT_W-1:0] count_r, count_s;

  // State, latched word, delay counter and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= 8'd0;
      word_a_r   <= 1'b0;
      word_b_r   <= 1'b0;
      in_ready_r <= 1'b0;
      a_t_r      <= 1'b0;
      b_t_r      <= 1'b0;
      clk_t_r    <= 1'b0;
      exp_q_r    <= 1'b0;
      count_r    <= '0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      word_a_r   <= word_a_s;
      word_b_r   <= word_b_s;
      in_ready_r <= in_ready_s;
      a_t_r      <= a_t_s;
      b_t_r      <= b_t_s;
      clk_t_r    <= clk_t_s;
      exp_q_r    <= exp_q_s;
      count_r    <= count_s;
    end
  end

  // Next-state and next-output logic; each SEND_x state flips its line on the following edge.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    word_a_s = word_a_r;
    word_b_s = word_b_r;
    a_t_s    = a_t_r;
    b_t_s    = b_t_r;
    clk_t_s  = clk_t_r;
    exp_q_s  = exp_q_r;
    count_s  = count_r;
    case (state_r)
      IDLE: begin
        if (in_valid && in_ready_r) begin
          word_a_s = in_a;
          word_b_s = in_b;
          if (in_a) begin
            state_s = SEND_A;
          end else if (in_b) begin
            state_s = SEND_B;
          end else begin
            state_s = SEND_CLK;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SEND_A: begin
        a_t_s = ~a_t_r;
        if (word_b_r) begin
          state_s = (GAP_LEN == 8'd0) ? SEND_B : GAP;
          cnt_s   = GAP_LEN;
        end else begin
          state_s = (SETUP_LEN == 8'd0) ? SEND_CLK : SETUP_W;
          cnt_s   = SETUP_LEN;
        end
      end
      GAP: begin
        if (cnt_r <= 8'd1) begin
          state_s = SEND_B;
        end else begin
          cnt_s = cnt_r - 8'd1;
        end
      end
      SEND_B: begin
        b_t_s   = ~b_t_r;
        state_s = (SETUP_LEN == 8'd0) ? SEND_CLK : SETUP_W;
        cnt_s   = SETUP_LEN;
      end
      SETUP_W: begin
        if (cnt_r <= 8'd1) begin
          state_s = SEND_CLK;
        end else begin
          cnt_s = cnt_r - 8'd1;
        end
      end
      SEND_CLK: begin
        clk_t_s = ~clk_t_r;
        exp_q_s = exp_q_r ^ (word_a_r ^ word_b_r);
        count_s = count_r + CNT_W'(1);
        state_s = (HOLD_LEN == 8'd0) ? IDLE : HOLD_W;
        cnt_s   = HOLD_LEN;
      end
      HOLD_W: begin
        if (cnt_r <= 8'd1) begin
          state_s = IDLE;
        end else begin
          cnt_s = cnt_r - 8'd1;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 8'd0;
      end
    endcase
    // Ready is registered: it rises on the edge that enters IDLE, so an accept can follow next edge.
    in_ready_s = (state_s == IDLE);
  end

  assign in_ready  = in_ready_r;
  assign a_t       = a_t_r;
  assign b_t       = b_t_r;
  assign clk_t     = clk_t_r;
  assign exp_q     = exp_q_r;
  assign clk_count = count_r;

endmodule

// File: tb/tb_rsfq_pulse_tx.sv
// Randomized bench for rsfq_pulse_tx against a schedule-based reference model.
module tb_rsfq_pulse_tx;
  localparam int AB_GAP = 8;
  localparam int SETUP  = 5;
  localparam int HOLD   = 5;
  localparam int CNT_W  = 16;
  localparam int NEVER  = 1 << 30;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic             in_a;
  logic             in_b;
  logic             a_t;
  logic             b_t;
  logic             clk_t;
  logic             exp_q;
  logic [CNT_W-1:0] clk_count;

  always #5 clk = ~clk;

  rsfq_pulse_tx #(.AB_GAP(AB_GAP), .SETUP(SETUP), .HOLD(HOLD), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .a_t(a_t), .b_t(b_t), .clk_t(clk_t),
    .exp_q(exp_q), .clk_count(clk_count)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit ma, mb, mc, mq, xr, rel, accepted;
  int mcount, ta, tb, tc, next_ok;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, got, exp);
  endtask

  task automatic model_reset();
    ma = 0; mb = 0; mc = 0; mq = 0; xr = 0;
    mcount = 0; ta = -1; tb = -1; tc = -1;
    next_ok = NEVER; rel = 1;
  endtask

  // Absolute edge numbers of each toggle for a word accepted at edge t0.
  task automatic schedule(input int t0, input bit a, input bit b);
    ta = -1; tb = -1;
    if (a && b) begin
      ta = t0 + 1; tb = t0 + 1 + AB_GAP; tc = tb + SETUP;
    end else if (a) begin
      ta = t0 + 1; tc = t0 + 1 + SETUP;
    end else if (b) begin
      tb = t0 + 1; tc = t0 + 1 + SETUP;
    end else begin
      tc = t0 + 1;
    end
    xr = a ^ b;
    next_ok = tc + HOLD;
  endtask

  task automatic check_outputs(input string ph);
    check_val({ph, ".a_t"}, 32'(a_t), 32'(ma));
    check_val({ph, ".b_t"}, 32'(b_t), 32'(mb));
    check_val({ph, ".clk_t"}, 32'(clk_t), 32'(mc));
    check_val({ph, ".exp_q"}, 32'(exp_q), 32'(mq));
    check_val({ph, ".clk_count"}, 32'(clk_count), 32'(mcount));
    check_val({ph, ".in_ready"}, 32'(in_ready), 32'(cyc + 1 >= next_ok));
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    accepted = 0;
    if (rst_n) begin
      if (rel) begin
        rel = 0; next_ok = cyc + 1;
      end
      if (cyc == ta) ma = !ma;
      if (cyc == tb) mb = !mb;
      if (cyc == tc) begin
        mc = !mc;
        if (xr) mq = !mq;
        mcount = (mcount + 1) % (1 << CNT_W);
      end
      if (in_valid && cyc >= next_ok) begin
        schedule(cyc, in_a, in_b);
        accepted = 1;
      end
    end
    #1;
    check_outputs("run");
  endtask

  task automatic do_reset(input int n);
    rst_n = 0;
    model_reset();
    #1;
    check_outputs("rst_async");
    repeat (n) step();
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0; in_valid = 1; in_a = 1; in_b = 1;
    model_reset();
    #1;
    check_outputs("rst_init");
    repeat (3) step();
    @(negedge clk);
    rst_n = 1;
    // Back-to-back {1,0} words with valid held high.
    in_a = 1; in_b = 0;
    repeat (40) step();
    in_valid = 0;
    repeat (15) step();
    // Reset shortly after an accept, then a single {0,1} word.
    in_valid = 1; in_a = 1; in_b = 0;
    step();
    in_valid = 0;
    repeat (2) step();
    do_reset(3);
    in_valid = 1; in_a = 0; in_b = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (accepted) in_valid = 0;
    end
    // Random traffic; a word is held until the model says it was taken.
    for (int i = 0; i < 3000; i++) begin
      step();
      if (accepted) in_valid = 0;
      if (!in_valid && $urandom_range(3) != 0) begin
        in_valid = 1;
        in_a = 1'($urandom_range(1));
        in_b = 1'($urandom_range(1));
      end
      if (i % 700 == 350) do_reset(2 + int'($urandom_range(2)));
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
